// File: rtl/vedic_mac_pkg.sv
// Shared types and widths for the vedic multiply-accumulate block.
package vedic_mac_pkg;

  localparam int unsigned OPND_W = 8;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/vedic_mac_vedic8bit.sv
// 8x8 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier built from 2x2 and 4x4 crosswise blocks.
module vedic8bit
  import vedic_mac_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [PROD_W-1:0] p_c
);

  // 2x2 block: vertical and crosswise bit products with half-adder carries
  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] r;
    logic       c1;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c1   = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c1;
    r[3] = (x[1] & y[1]) & c1;
    return r;
  endfunction

  // 4x4 block: four 2x2 partial products, cross terms summed then shifted in
  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] ll, lh, hl, hh;
    logic [4:0] mid;
    ll  = mul2(x[1:0], y[1:0]);
    lh  = mul2(x[1:0], y[3:2]);
    hl  = mul2(x[3:2], y[1:0]);
    hh  = mul2(x[3:2], y[3:2]);
    mid = 5'(lh) + 5'(hl);
    return 8'(ll) + (8'(mid) << 2) + (8'(hh) << 4);
  endfunction

  // 8x8 block: same crosswise structure one level up
  function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] ll, lh, hl, hh;
    logic [8:0] mid;
    ll  = mul4(x[3:0], y[3:0]);
    lh  = mul4(x[3:0], y[7:4]);
    hl  = mul4(x[7:4], y[3:0]);
    hh  = mul4(x[7:4], y[7:4]);
    mid = 9'(lh) + 9'(hl);
    return 16'(ll) + (16'(mid) << 4) + (16'(hh) << 8);
  endfunction

  assign p_c = PROD_W'(mul8(a, b));

endmodule

// File: rtl/vedic_mac.sv
// Three-stage burst multiply-accumulate: S1 operand capture, S2 vedic product, S3 accumulate.
module vedic_mac
  import vedic_mac_pkg::*;
#(
  parameter int unsigned ACC_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_a,
  input  logic [7:0]        in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic              accept_c;
  logic [OPND_W-1:0] s1_a, s1_b;
  logic              s1_last, s1_valid;
  logic [PROD_W-1:0] s1_prod_c;
  logic [PROD_W-1:0] s2_prod;
  logic              s2_last, s2_valid;
  logic [SUM_W-1:0]  sum_c;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              closed_q, closed_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  assign accept_c = in_valid && in_ready_q;
  assign sum_c    = {1'b0, acc_q} + SUM_W'(s2_prod);

  vedic8bit u_mul (
    .a   (s1_a),
    .b   (s1_b),
    .p_c (s1_prod_c)
  );

  // Pipeline stages S1 and S2; payload only loads alongside a valid beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a     <= '0;
      s1_b     <= '0;
      s1_last  <= 1'b0;
      s1_valid <= 1'b0;
      s2_prod  <= '0;
      s2_last  <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_last <= in_last;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= s1_prod_c;
        s2_last <= s1_last;
      end
    end
  end

  // State, accumulator and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      closed_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      closed_q    <= closed_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state: S3 accumulation, burst close on last, clear on result handshake
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    closed_d = closed_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) state_d = ACCUM;
      end
      ACCUM: begin
        if (s2_valid) begin
          acc_d = sum_c[ACC_W-1:0];
          ovf_d = ovf_q | sum_c[ACC_W];
          if (s2_last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d  = IDLE;
          acc_d    = '0;
          ovf_d    = 1'b0;
          closed_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A burst is closed once its last beat enters; no new beats until the result is taken
    if (accept_c && in_last) closed_d = 1'b1;
    in_ready_d  = !closed_d;
    out_valid_d = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_vedic_mac.sv
// Directed and randomized bursts checked against a plain sum-of-products model.
module tb_vedic_mac;

  localparam int unsigned ACC_W = 24;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  int vectors;
  int miscompares;
  int qa[$];
  int qb[$];

  vedic_mac #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int a, input int b, input int count);
    for (int i = 0; i < count; i++) begin
      qa.push_back(a);
      qb.push_back(b);
    end
  endtask

  // Drive the queued beats as one burst, then collect and check the result
  task automatic run_burst(input int valid_pct, input int ready_pct,
                           input int gap_at, input int gap_len, input int stall);
    int          n;
    longint      s;
    int          idx;
    int          budget;
    int          lat;
    int          gl;
    int          k;
    logic [31:0] ea;
    logic [31:0] eo;
    n   = qa.size();
    s   = 0;
    idx = 0;
    gl  = gap_len;
    for (int i = 0; i < n; i++) s += longint'(qa[i]) * longint'(qb[i]);
    ea     = 32'(s % (longint'(1) << ACC_W));
    eo     = (s >= (longint'(1) << ACC_W)) ? 32'd1 : 32'd0;
    budget = 40 * n + 100;
    while (idx < n && budget > 0) begin
      @(negedge clk);
      budget--;
      check("in_ready_burst", 32'(in_ready), 32'd1);
      if (idx == gap_at && gl > 0) begin
        in_valid = 1'b0;
        gl--;
      end else begin
        in_valid = ($urandom_range(99) < 32'(valid_pct));
      end
      in_a    = 8'(qa[idx]);
      in_b    = 8'(qb[idx]);
      in_last = (idx == n - 1);
      if (in_valid && in_ready) idx++;
    end
    check("beats_accepted", 32'(idx), 32'(n));
    qa.delete();
    qb.delete();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (idx != n) return;
    lat = 1;
    while (!out_valid && lat < 20) begin
      check("in_ready_closed", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("result_latency", 32'(lat), 32'd3);
    if (!out_valid) return;
    k      = 0;
    budget = 300 + stall;
    forever begin
      check("out_acc", 32'(out_acc), ea);
      check("out_ovf", 32'(out_ovf), eo);
      check("in_ready_done", 32'(in_ready), 32'd0);
      if (k < stall) out_ready = 1'b0;
      else if (budget <= 0) out_ready = 1'b1;
      else out_ready = ($urandom_range(99) < 32'(ready_pct));
      budget--;
      @(negedge clk);
      if (out_ready) break;
      k++;
      check("out_valid_stall", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b0;
    check("out_valid_taken", 32'(out_valid), 32'd0);
    check("in_ready_reopen", 32'(in_ready), 32'd1);
    check("acc_cleared", 32'(out_acc), 32'd0);
    check("ovf_cleared", 32'(out_ovf), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_last     = 1'b0;
    out_ready   = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_acc", 32'(out_acc), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 32'(in_ready), 32'd1);

    // Single beat 3*5
    push(3, 5, 1);
    run_burst(100, 100, -1, 0, 0);

    // 258 and 259 full-scale beats around the 24-bit wrap
    push(255, 255, 258);
    run_burst(100, 100, -1, 0, 0);
    push(255, 255, 259);
    run_burst(100, 100, -1, 0, 0);

    // Zero operand, idle gap, then a stalled result
    push(10, 20, 1);
    push(0, 7, 1);
    push(4, 4, 1);
    run_burst(100, 100, 2, 3, 5);
    push(1, 1, 1);
    run_burst(100, 100, -1, 0, 0);

    // Zero-valued last beats
    push(7, 9, 1);
    push(0, 5, 1);
    run_burst(100, 100, -1, 0, 0);
    push(0, 0, 1);
    run_burst(100, 100, -1, 0, 2);

    // Reset mid-burst leaves nothing behind
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 8'd100;
    in_b     = 8'd100;
    in_last  = 1'b0;
    check("pre_rst_ready0", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("pre_rst_ready1", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_acc", 32'(out_acc), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", 32'(in_ready), 32'd1);
    push(2, 3, 1);
    run_burst(100, 100, -1, 0, 0);

    // Random bursts with random valid/ready
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 300));
      for (int i = 0; i < n; i++) begin
        if (r % 2 == 1) push(int'($urandom_range(200, 255)), int'($urandom_range(200, 255)), 1);
        else push(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1);
      end
      run_burst(int'($urandom_range(40, 100)), 50, -1, 0, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
